// File: rtl/mcyc_ctrl.sv
`timescale 1ns / 1ps
// mcyc_ctrl -- machine-cycle and T-state sequencer for the 8085 core.
//
// Walks the opcode fetch (M1 T1..T4, optional T5/T6) and up to four further
// machine cycles (M2..M5) described by the decoded instruction info latched at
// M1 T4. It drives the ALU/register enables and the external bus strobes, and
// parks in a halt state that only reset leaves.
//
// Ports
//   clk     in   system clock, one T-state per rising edge
//   rst_    in   synchronous active-low reset
//   chk_i   in   decoded instruction info, sampled only at the end of M1 T4
//   ready   in   memory ready (only used when wait states are compiled in)
//   ienb    out  enables: RRD0 RWR1 COD2 EXT3 PC_4 PD_5 NXT6 ALE7 3RD8
//   ale     out  address latch enable
//   rd_     out  bus read strobe, active-low
//   wr_     out  bus write strobe, active-low
//   halt    out  core halted
//   mcyc    out  current machine cycle 1..5
//   tstate  out  current T-state 1..6, 7 = Tw
//
// Optional feature: define MCYC_WAIT_STATE_EN to insert Tw states while
// ready is low at the end of T2 of a bus cycle.
//
// All outputs are registered: they are decoded from the next-state values so
// that they line up with the state they describe.
module mcyc_ctrl #(
   parameter int unsigned IENBSIZE = 9,
   parameter int unsigned INSTSIZE = 19
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic [INSTSIZE-1:0] chk_i,
   input  logic                ready,
   output logic [IENBSIZE-1:0] ienb,
   output logic                ale,
   output logic                rd_,
   output logic                wr_,
   output logic                halt,
   output logic [2:0]          mcyc,
   output logic [2:0]          tstate
);

   localparam int unsigned EnRrd = 0;
   localparam int unsigned EnRwr = 1;
   localparam int unsigned EnCod = 2;
   localparam int unsigned EnExt = 3;
   localparam int unsigned EnPc  = 4;
   localparam int unsigned EnPd  = 5;
   localparam int unsigned EnNxt = 6;
   localparam int unsigned EnAle = 7;
   localparam int unsigned En3rd = 8;

   // StRst is the idle cycle right after reset; the fetch starts one edge later.
   typedef enum logic [3:0] {
      StRst, StT1, StT2, StT3, StT4, StT5, StT6, StTw, StHalt
   } state_e;

   state_e              st_q, st_d;
   logic [2:0]          mcyc_q, mcyc_d;
   logic [11:0]         cycinfo_q, cycinfo_d;   // {CD, RW, CYC}
   logic                dad_q, dad_d;
   logic [IENBSIZE-1:0] ienb_q, ienb_d;
   logic                ale_q, ale_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                halt_q, halt_d;
   logic [2:0]          tstate_q, tstate_d;

   logic                more_cyc;
   logic [1:0]          k_d;
   logic                cd_k;
   logic                rw_k;
   logic                unused_chk;

   // DIO, INST_ALE, INST_CTL and CCC have no effect in this revision.
   assign unused_chk = ^{chk_i[INSTSIZE-1:16], chk_i[3]};

   // Next state
   always_comb begin
      st_d      = st_q;
      mcyc_d    = mcyc_q;
      cycinfo_d = cycinfo_q;
      dad_d     = dad_q;

      // CYC bit of the machine cycle after the current one
      case (mcyc_q)
         3'd2:    more_cyc = cycinfo_q[1];
         3'd3:    more_cyc = cycinfo_q[2];
         3'd4:    more_cyc = cycinfo_q[3];
         default: more_cyc = 1'b0;
      endcase

      unique case (st_q)
         StRst: st_d = StT1;
         StT1:  st_d = StT2;
         StT2: begin
            st_d = StT3;
`ifdef MCYC_WAIT_STATE_EN
            // DAD machine cycles are internal and never wait
            if (((mcyc_q == 3'd1) || !dad_q) && !ready) st_d = StTw;
`endif
         end
         StTw: if (ready) st_d = StT3;
         StT3: begin
            if (mcyc_q == 3'd1) begin
               st_d = StT4;
            end else begin
               st_d   = StT1;
               mcyc_d = more_cyc ? mcyc_q + 3'd1 : 3'd1;
            end
         end
         StT4: begin
            cycinfo_d = chk_i[15:4];
            dad_d     = chk_i[1];
            if (chk_i[2]) begin
               st_d = StHalt;
            end else if (chk_i[0]) begin
               st_d = StT5;
            end else begin
               st_d   = StT1;
               mcyc_d = (chk_i[7:4] != 4'd0) ? 3'd2 : 3'd1;
            end
         end
         StT5: st_d = StT6;
         StT6: begin
            st_d   = StT1;
            mcyc_d = (cycinfo_q[3:0] != 4'd0) ? 3'd2 : 3'd1;
         end
         StHalt:  st_d = StHalt;
         default: st_d = StRst;
      endcase
   end

   // Output decode of the next state
   always_comb begin
      ienb_d   = '0;
      ale_d    = 1'b0;
      rd_d     = 1'b1;
      wr_d     = 1'b1;
      halt_d   = 1'b0;
      k_d      = 2'(mcyc_d - 3'd2);
      cd_k     = cycinfo_d[{2'b10, k_d}];
      rw_k     = cycinfo_d[{2'b01, k_d}];

      case (st_d)
         StT2:    tstate_d = 3'd2;
         StT3:    tstate_d = 3'd3;
         StT4:    tstate_d = 3'd4;
         StT5:    tstate_d = 3'd5;
         StT6:    tstate_d = 3'd6;
         StTw:    tstate_d = 3'd7;
         default: tstate_d = 3'd1;
      endcase

      if (st_d == StHalt) begin
         halt_d = 1'b1;
      end else if (st_d != StRst) begin
         if (mcyc_d == 3'd1) begin
            unique case (st_d)
               StT1: begin
                  ale_d         = 1'b1;
                  ienb_d[EnAle] = 1'b1;
                  ienb_d[EnPc]  = 1'b1;
               end
               StT2, StTw: rd_d = 1'b0;
               StT3: begin
                  rd_d          = 1'b0;
                  ienb_d[EnCod] = 1'b1;
               end
               StT4: ienb_d[EnRrd] = 1'b1;
               StT5: ienb_d[EnExt] = 1'b1;
               StT6: begin
                  ienb_d[EnExt] = 1'b1;
                  ienb_d[EnRwr] = (cycinfo_d[3:0] == 4'd0);
               end
               default: ;
            endcase
         end else begin
            ienb_d[EnPd]  = cd_k;
            ienb_d[EnNxt] = ~mcyc_d[0];   // low byte in M2/M4
            if (dad_d) begin
               if (st_d == StT3) ienb_d[EnRwr] = 1'b1;
            end else if (rw_k) begin
               ienb_d[EnRrd] = 1'b1;
               if (st_d == StT1) begin
                  ale_d         = 1'b1;
                  ienb_d[EnAle] = 1'b1;
               end else begin
                  wr_d = 1'b0;
               end
            end else begin
               unique case (st_d)
                  StT1: begin
                     ale_d         = 1'b1;
                     ienb_d[EnAle] = 1'b1;
                  end
                  StT2: begin
                     rd_d         = 1'b0;
                     ienb_d[EnPc] = ~cd_k;
                  end
                  StTw: rd_d = 1'b0;
                  StT3: begin
                     rd_d          = 1'b0;
                     ienb_d[EnRwr] = 1'b1;
                     ienb_d[En3rd] = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         st_q      <= StRst;
         mcyc_q    <= 3'd1;
         cycinfo_q <= '0;
         dad_q     <= 1'b0;
         ienb_q    <= '0;
         ale_q     <= 1'b0;
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
         halt_q    <= 1'b0;
         tstate_q  <= 3'd1;
      end else begin
         st_q      <= st_d;
         mcyc_q    <= mcyc_d;
         cycinfo_q <= cycinfo_d;
         dad_q     <= dad_d;
         ienb_q    <= ienb_d;
         ale_q     <= ale_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         halt_q    <= halt_d;
         tstate_q  <= tstate_d;
      end
   end

   assign ienb   = ienb_q;
   assign ale    = ale_q;
   assign rd_    = rd_q;
   assign wr_    = wr_q;
   assign halt   = halt_q;
   assign mcyc   = mcyc_q;
   assign tstate = tstate_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
`timescale 1ns / 1ps
// Bench for mcyc_ctrl: a cycle-by-cycle plan of inputs and expected outputs is
// built from the instruction-level behaviour, then a driver replays it while a
// monitor pops expected outputs from a scoreboard queue and compares.
module tb_mcyc_ctrl;

   localparam int RRD = 0, RWR = 1, COD = 2, EXT = 3, PC = 4, PD = 5, NXT = 6, ALE = 7, TRD = 8;

   typedef struct packed {
      logic        rst;    // inputs held during this cycle, sampled at its closing edge
      logic [18:0] chk;
      logic        rdy;
      logic        vld;    // outputs of this cycle are known
      logic        pos;    // mcyc/tstate of this cycle are checked
      logic [8:0]  ienb;
      logic        ale;
      logic        rd;
      logic        wr;
      logic        halt;
      logic [2:0]  mc;
      logic [2:0]  ts;
   } cyc_t;

   logic        clk = 1'b1;
   logic        rst_;
   logic [18:0] chk_i;
   logic        ready;
   logic [8:0]  ienb;
   logic        ale, rd_, wr_, halt;
   logic [2:0]  mcyc, tstate;

   cyc_t plan[$];
   cyc_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   mcyc_ctrl #(.IENBSIZE(9), .INSTSIZE(19)) dut (
      .clk   (clk),
      .rst_  (rst_),
      .chk_i (chk_i),
      .ready (ready),
      .ienb  (ienb),
      .ale   (ale),
      .rd_   (rd_),
      .wr_   (wr_),
      .halt  (halt),
      .mcyc  (mcyc),
      .tstate(tstate)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] eb(input int i);
      eb = 9'd1 << i;
   endfunction

   task automatic add(input logic [8:0] en, input logic a, input logic r, input logic w,
                      input logic h, input int mc, input int ts, input bit pos);
      cyc_t c;
      c.rst = 1'b1; c.chk = 19'($urandom); c.rdy = 1'($urandom);
      c.vld = 1'b1; c.pos = pos; c.ienb = en; c.ale = a; c.rd = r; c.wr = w; c.halt = h;
      c.mc = 3'(mc); c.ts = 3'(ts);
      plan.push_back(c);
   endtask

   task automatic set_last_rdy(input logic v);
      cyc_t c;
      c = plan[plan.size()-1]; c.rdy = v; plan[plan.size()-1] = c;
   endtask

   task automatic set_last_chk(input logic [18:0] v);
      cyc_t c;
      c = plan[plan.size()-1]; c.chk = v; plan[plan.size()-1] = c;
   endtask

   // Reset asserted at the closing edge of the last planned cycle, n times.
   task automatic add_reset(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c = plan[plan.size()-1]; c.rst = 1'b0; plan[plan.size()-1] = c;
         add(9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1'b1);
      end
   endtask

   // T2 of a bus cycle followed by nw requested wait states.
   task automatic add_t2(input logic [8:0] en2, input logic [8:0] enw, input logic r,
                         input logic w, input int mc, input int nw);
      add(en2, 1'b0, r, w, 1'b0, mc, 2, 1'b1);
`ifdef MCYC_WAIT_STATE_EN
      for (int i = 0; i < nw; i++) begin
         set_last_rdy(1'b0);
         add(enw, 1'b0, r, w, 1'b0, mc, 7, 1'b1);
      end
      set_last_rdy(1'b1);
`else
      if (nw > 0) set_last_rdy(1'b0);
`endif
   endtask

   // One instruction; w holds a 2-bit wait count per machine cycle (M1 at [1:0]).
   task automatic add_instr(input logic [18:0] c, input logic [9:0] w);
      logic [3:0] cy, rw, cd;
      logic [8:0] b;
      int         mc;
      cy = c[7:4]; rw = c[11:8]; cd = c[15:12];
      add(eb(ALE) | eb(PC), 1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 1'b1);
      add_t2(9'd0, 9'd0, 1'b0, 1'b1, 1, int'(w[1:0]));
      add(eb(COD), 1'b0, 1'b0, 1'b1, 1'b0, 1, 3, 1'b1);
      add(eb(RRD), 1'b0, 1'b1, 1'b1, 1'b0, 1, 4, 1'b1);
      set_last_chk(c);
      if (c[2]) return;
      if (c[0]) begin
         add(eb(EXT), 1'b0, 1'b1, 1'b1, 1'b0, 1, 5, 1'b1);
         add(eb(EXT) | ((cy == 4'd0) ? eb(RWR) : 9'd0), 1'b0, 1'b1, 1'b1, 1'b0, 1, 6, 1'b1);
      end
      for (int k = 0; k < 4 && cy[k]; k++) begin
         mc = k + 2;
         b  = (cd[k] ? eb(PD) : 9'd0) | ((k % 2 == 0) ? eb(NXT) : 9'd0);
         if (c[1]) begin
            add(b, 1'b0, 1'b1, 1'b1, 1'b0, mc, 1, 1'b1);
            add(b, 1'b0, 1'b1, 1'b1, 1'b0, mc, 2, 1'b1);
            add(b | eb(RWR), 1'b0, 1'b1, 1'b1, 1'b0, mc, 3, 1'b1);
         end else if (rw[k]) begin
            add(b | eb(RRD) | eb(ALE), 1'b1, 1'b1, 1'b1, 1'b0, mc, 1, 1'b1);
            add_t2(b | eb(RRD), b | eb(RRD), 1'b1, 1'b0, mc, int'(w[2*(k+1) +: 2]));
            add(b | eb(RRD), 1'b0, 1'b1, 1'b0, 1'b0, mc, 3, 1'b1);
         end else begin
            add(b | eb(ALE), 1'b1, 1'b1, 1'b1, 1'b0, mc, 1, 1'b1);
            add_t2(b | (cd[k] ? 9'd0 : eb(PC)), b, 1'b0, 1'b1, mc, int'(w[2*(k+1) +: 2]));
            add(b | eb(RWR) | eb(TRD), 1'b0, 1'b0, 1'b1, 1'b0, mc, 3, 1'b1);
         end
      end
   endtask

   // Instruction cut short by a reset at the end of its n-th cycle.
   task automatic add_abort(input logic [18:0] c, input logic [9:0] w, input int n);
      int s;
      s = plan.size();
      add_instr(c, w);
      while (plan.size() > s + n) void'(plan.pop_back());
      add_reset(1);
   endtask

   task automatic add_halt(input int n);
      for (int i = 0; i < n; i++) add(9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0);
   endtask

   // Monitor: one scoreboard entry per cycle, sampled at the falling edge.
   initial begin
      cyc_t        e;
      logic [12:0] got, want;
      int          cyc_n;
      cyc_n = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.vld) begin
               got  = {ienb, ale, rd_, wr_, halt};
               want = {e.ienb, e.ale, e.rd, e.wr, e.halt};
               n_chk++;
               if (got !== want) begin
                  n_err++;
                  $display("FAIL outputs cycle %0d: got ienb=%b ale=%b rd_=%b wr_=%b halt=%b, want ienb=%b ale=%b rd_=%b wr_=%b halt=%b",
                           cyc_n, ienb, ale, rd_, wr_, halt, e.ienb, e.ale, e.rd, e.wr, e.halt);
               end
               if (e.pos) begin
                  n_chk++;
                  if ({mcyc, tstate} !== {e.mc, e.ts}) begin
                     n_err++;
                     $display("FAIL position cycle %0d: got M%0d T%0d, want M%0d T%0d",
                              cyc_n, mcyc, tstate, e.mc, e.ts);
                  end
               end
            end
            cyc_n++;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cyc_t c;
      rst_  = 1'b0;
      chk_i = '0;
      ready = 1'b1;

      c = '0;                                   // cycle before the first edge
      c.rst = 1'b0; c.rdy = 1'b1;
      plan.push_back(c);
      add_reset(2);

      add_instr(19'h00000, 10'd0);              // NOP
      add_instr(19'h00000, 10'd0);
      add_instr(19'h00001, 10'd0);              // INX
      add_instr(19'h01110, 10'd0);              // MOV M,r
      add_instr(19'h00030, 10'd0);              // LXI
      add_instr(19'h00032, 10'd0);              // DAD
      add_instr(19'h00000, 10'd2);              // NOP, two wait states in M1
      add_instr(19'h01110, 10'b01_01);          // MOV M,r with waits
      add_instr(19'h00071, 10'b11_10_01_00);    // GO6 then three reads with waits

      for (int i = 0; i < 60; i++) begin
         logic [18:0] ci;
         int          n;
         n  = $urandom_range(0, 4);
         ci = 19'($urandom);
         ci[7:4] = 4'((1 << n) - 1);
         ci[2]   = 1'b0;
         ci[0]   = ($urandom_range(0, 3) == 0);
         ci[1]   = ($urandom_range(0, 4) == 0);
         add_instr(ci, 10'($urandom & $urandom));
      end

      add_abort(19'h00030, 10'd0, 5);           // reset in LXI M2 T1
      add_instr(19'h00000, 10'd0);
      add_abort(19'h00000, 10'd3, 3);           // reset in Tw (T3 without waits)
      add_instr(19'h01110, 10'd0);
      add_abort(19'h00071, 10'd0, $urandom_range(1, 12));
      add_instr(19'h00000, 10'd0);

      add_instr(19'h00004, 10'd0);              // HLT
      add_halt(20);
      add_reset(1);
      add_instr(19'h00000, 10'd0);
      add_instr(19'h00030, 10'd0);

      for (int i = 0; i < plan.size(); i++) begin
         rst_  = plan[i].rst;
         chk_i = plan[i].chk;
         ready = plan[i].rdy;
         exp_q.push_back(plan[i]);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
